// File: rtl/nic_shell_lite.sv
// Reduced NIC shell datapath core: RX frame checking with round-robin queue
// assignment, TX pass-through, and a small statistics/control register port.
module nic_shell_lite #(
  parameter logic [31:0] BUILD_TIMESTAMP = 32'h01010000,
  parameter int          MIN_PKT_LEN     = 64,
  parameter int          MAX_PKT_LEN     = 1518,
  parameter int          NUM_QUEUE       = 512,
  parameter int          DATA_WIDTH      = 512
) (
  input  logic                      cmac_clk,
  input  logic                      cmac_rst,
  input  logic                      reg_wr,
  input  logic                      reg_rd,
  input  logic [15:0]               reg_addr,
  input  logic [31:0]               reg_wdata,
  output logic [31:0]               reg_rdata,
  output logic                      reg_rvalid,
  input  logic                      s_axis_cmac_rx_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_cmac_rx_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_cmac_rx_tkeep,
  input  logic                      s_axis_cmac_rx_tlast,
  input  logic                      s_axis_cmac_rx_tuser_err,
  output logic                      m_axis_rx_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_rx_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_rx_tkeep,
  output logic                      m_axis_rx_tlast,
  output logic                      m_axis_rx_tuser_err,
  output logic [15:0]               m_axis_rx_tuser_qid,
  input  logic                      s_axis_tx_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_tx_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tx_tkeep,
  input  logic                      s_axis_tx_tlast,
  output logic                      s_axis_tx_tready,
  output logic                      m_axis_cmac_tx_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_cmac_tx_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_cmac_tx_tkeep,
  output logic                      m_axis_cmac_tx_tlast,
  input  logic                      m_axis_cmac_tx_tready
);

  localparam int          KEEP_W  = DATA_WIDTH / 8;
  localparam logic [15:0] MIN_LEN = 16'(MIN_PKT_LEN);
  localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);
  localparam logic [15:0] NUM_Q   = 16'(NUM_QUEUE);

  logic [15:0] queue_count;
  logic [15:0] qcount_lat;
  logic [15:0] qptr;
  logic [15:0] qid_hold;
  logic [15:0] len_acc;
  logic        in_frame;
  logic [31:0] rx_ok_cnt;
  logic [31:0] rx_bad_cnt;
  logic [31:0] tx_cnt;

  logic [15:0] beat_bytes;
  logic [16:0] len_sum;
  logic [15:0] len_now;
  logic        frame_bad;
  logic        first_beat;
  logic [15:0] frame_qcount;
  logic [15:0] qid_cur;
  logic [15:0] ptr_inc;
  logic [15:0] ptr_wrap;
  logic        qcount_wr;
  logic [15:0] qcount_wval;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^reg_wdata[31:16];

  assign m_axis_cmac_tx_tvalid = s_axis_tx_tvalid;
  assign m_axis_cmac_tx_tdata  = s_axis_tx_tdata;
  assign m_axis_cmac_tx_tkeep  = s_axis_tx_tkeep;
  assign m_axis_cmac_tx_tlast  = s_axis_tx_tlast;
  assign s_axis_tx_tready      = m_axis_cmac_tx_tready;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + 16'(s_axis_cmac_rx_tkeep[i]);
    end
  end

  assign len_sum   = {1'b0, len_acc} + {1'b0, beat_bytes};
  assign len_now   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign frame_bad = s_axis_cmac_rx_tuser_err | (len_now < MIN_LEN) | (len_now > MAX_LEN);

  // A queue-count change is only seen by frames that start after it lands.
  assign first_beat   = ~in_frame;
  assign frame_qcount = first_beat ? queue_count : qcount_lat;
  assign qid_cur      = first_beat ? ((queue_count == 16'd0) ? 16'd0 : qptr) : qid_hold;
  assign ptr_inc      = qptr + 16'd1;
  assign ptr_wrap     = (ptr_inc >= frame_qcount) ? 16'd0 : ptr_inc;

  assign qcount_wr   = reg_wr && (reg_addr == 16'h1000);
  assign qcount_wval = (reg_wdata[15:0] > NUM_Q) ? NUM_Q : reg_wdata[15:0];

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      16'h0000: rd_mux = BUILD_TIMESTAMP;
      16'h1000: rd_mux = {16'd0, queue_count};
      16'h2000: rd_mux = rx_ok_cnt;
      16'h2004: rd_mux = rx_bad_cnt;
      16'h2008: rd_mux = tx_cnt;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge cmac_clk) begin
    if (cmac_rst) begin
      reg_rvalid          <= 1'b0;
      reg_rdata           <= '0;
      queue_count         <= '0;
      qcount_lat          <= '0;
      qptr                <= '0;
      qid_hold            <= '0;
      len_acc             <= '0;
      in_frame            <= 1'b0;
      rx_ok_cnt           <= '0;
      rx_bad_cnt          <= '0;
      tx_cnt              <= '0;
      m_axis_rx_tvalid    <= 1'b0;
      m_axis_rx_tdata     <= '0;
      m_axis_rx_tkeep     <= '0;
      m_axis_rx_tlast     <= 1'b0;
      m_axis_rx_tuser_err <= 1'b0;
      m_axis_rx_tuser_qid <= '0;
    end else begin
      reg_rvalid <= reg_rd;
      if (reg_rd) reg_rdata <= rd_mux;
      if (qcount_wr) queue_count <= qcount_wval;

      m_axis_rx_tvalid <= s_axis_cmac_rx_tvalid;
      if (s_axis_cmac_rx_tvalid) begin
        m_axis_rx_tdata     <= s_axis_cmac_rx_tdata;
        m_axis_rx_tkeep     <= s_axis_cmac_rx_tkeep;
        m_axis_rx_tlast     <= s_axis_cmac_rx_tlast;
        m_axis_rx_tuser_err <= s_axis_cmac_rx_tlast & frame_bad;
        m_axis_rx_tuser_qid <= qid_cur;
        if (first_beat) begin
          qcount_lat <= queue_count;
          qid_hold   <= qid_cur;
        end
        in_frame <= ~s_axis_cmac_rx_tlast;
        len_acc  <= s_axis_cmac_rx_tlast ? 16'd0 : len_now;
        if (s_axis_cmac_rx_tlast) begin
          if (frame_bad) rx_bad_cnt <= rx_bad_cnt + 32'd1;
          else           rx_ok_cnt  <= rx_ok_cnt + 32'd1;
        end
      end

      // A write to the queue-count register restarts the rotation.
      if (qcount_wr)
        qptr <= '0;
      else if (s_axis_cmac_rx_tvalid && s_axis_cmac_rx_tlast)
        qptr <= ptr_wrap;

      if (s_axis_tx_tvalid && m_axis_cmac_tx_tready && s_axis_tx_tlast)
        tx_cnt <= tx_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_nic_shell_lite.sv
// Directed self-checking bench for nic_shell_lite: registers, RX checking and
// queue rotation, TX pass-through and reset in the middle of a frame.
module tb_nic_shell_lite;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic          cmac_clk = 1'b0;
  logic          cmac_rst;
  logic          reg_wr, reg_rd;
  logic [15:0]   reg_addr;
  logic [31:0]   reg_wdata, reg_rdata;
  logic          reg_rvalid;
  logic          rx_in_valid, rx_in_last, rx_in_err;
  logic [DW-1:0] rx_in_data;
  logic [KW-1:0] rx_in_keep;
  logic          rx_out_valid, rx_out_last, rx_out_err;
  logic [DW-1:0] rx_out_data;
  logic [KW-1:0] rx_out_keep;
  logic [15:0]   rx_out_qid;
  logic          tx_in_valid, tx_in_last, tx_in_ready;
  logic [DW-1:0] tx_in_data;
  logic [KW-1:0] tx_in_keep;
  logic          tx_out_valid, tx_out_last, tx_out_ready;
  logic [DW-1:0] tx_out_data;
  logic [KW-1:0] tx_out_keep;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 cmac_clk = ~cmac_clk;

  nic_shell_lite dut (
    .cmac_clk                (cmac_clk),
    .cmac_rst                (cmac_rst),
    .reg_wr                  (reg_wr),
    .reg_rd                  (reg_rd),
    .reg_addr                (reg_addr),
    .reg_wdata               (reg_wdata),
    .reg_rdata               (reg_rdata),
    .reg_rvalid              (reg_rvalid),
    .s_axis_cmac_rx_tvalid   (rx_in_valid),
    .s_axis_cmac_rx_tdata    (rx_in_data),
    .s_axis_cmac_rx_tkeep    (rx_in_keep),
    .s_axis_cmac_rx_tlast    (rx_in_last),
    .s_axis_cmac_rx_tuser_err(rx_in_err),
    .m_axis_rx_tvalid        (rx_out_valid),
    .m_axis_rx_tdata         (rx_out_data),
    .m_axis_rx_tkeep         (rx_out_keep),
    .m_axis_rx_tlast         (rx_out_last),
    .m_axis_rx_tuser_err     (rx_out_err),
    .m_axis_rx_tuser_qid     (rx_out_qid),
    .s_axis_tx_tvalid        (tx_in_valid),
    .s_axis_tx_tdata         (tx_in_data),
    .s_axis_tx_tkeep         (tx_in_keep),
    .s_axis_tx_tlast         (tx_in_last),
    .s_axis_tx_tready        (tx_in_ready),
    .m_axis_cmac_tx_tvalid   (tx_out_valid),
    .m_axis_cmac_tx_tdata    (tx_out_data),
    .m_axis_cmac_tx_tkeep    (tx_out_keep),
    .m_axis_cmac_tx_tlast    (tx_out_last),
    .m_axis_cmac_tx_tready   (tx_out_ready)
  );

  task automatic reg_read(input logic [15:0] addr, output logic [31:0] data, output logic vld);
    @(negedge cmac_clk);
    reg_rd = 1'b1; reg_addr = addr;
    @(negedge cmac_clk);
    reg_rd = 1'b0;
    vld = reg_rvalid; data = reg_rdata;
  endtask

  task automatic reg_write(input logic [15:0] addr, input logic [31:0] data);
    @(negedge cmac_clk);
    reg_wr = 1'b1; reg_addr = addr; reg_wdata = data;
    @(negedge cmac_clk);
    reg_wr = 1'b0;
  endtask

  // Sends one frame of len bytes; records what emerges on the RX output.
  // bad_beats counts output beats whose data/keep/last/qid/err differ from the
  // beat that was driven (qid must stay constant, err must be 0 before last).
  task automatic send_frame(input int len, input logic err_in,
                            output int beats_out, output logic got_err,
                            output logic [15:0] got_qid, output int bad_beats);
    int nbeats;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
    logic [15:0] q0;
    int rem;
    nbeats = (len + 63) / 64;
    beats_out = 0; bad_beats = 0; got_err = 1'bx; got_qid = 16'hDEAD; q0 = 16'hDEAD;
    for (int c = 0; c < nbeats + 2; c++) begin
      @(negedge cmac_clk);
      if (rx_out_valid) begin
        d = {16{16'(len), 16'(beats_out)}};
        rem = (beats_out == nbeats - 1) ? len - 64 * (nbeats - 1) : 64;
        k = (rem == 64) ? '1 : ((64'd1 << rem) - 64'd1);
        if (beats_out == 0) q0 = rx_out_qid;
        if (rx_out_data !== d || rx_out_keep !== k || rx_out_qid !== q0 ||
            rx_out_last !== (beats_out == nbeats - 1)) bad_beats++;
        if (!rx_out_last && rx_out_err !== 1'b0) bad_beats++;
        if (rx_out_last) begin got_err = rx_out_err; got_qid = rx_out_qid; end
        beats_out++;
      end
      if (c < nbeats) begin
        rem = (c == nbeats - 1) ? len - 64 * (nbeats - 1) : 64;
        rx_in_valid = 1'b1;
        rx_in_data  = {16{16'(len), 16'(c)}};
        rx_in_keep  = (rem == 64) ? '1 : ((64'd1 << rem) - 64'd1);
        rx_in_last  = (c == nbeats - 1);
        rx_in_err   = err_in && (c == nbeats - 1);
      end else begin
        rx_in_valid = 1'b0; rx_in_last = 1'b0; rx_in_err = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    cmac_rst = 1'b1;
    repeat (3) @(negedge cmac_clk);
    total_cnt++;
    if (rx_out_valid !== 1'b0 || reg_rvalid !== 1'b0 || reg_rdata !== 32'd0 || tx_out_valid !== 1'b0)
      $display("FAIL reset_outputs: rx_valid=%b rvalid=%b rdata=%h tx_valid=%b, required 0/0/0/0",
               rx_out_valid, reg_rvalid, reg_rdata, tx_out_valid);
    else pass_cnt++;
    cmac_rst = 1'b0;
    reg_read(16'h0000, d, v);
    total_cnt++;
    if (v !== 1'b1 || d !== 32'h01010000) $display("FAIL read_timestamp: v=%b d=%h, required 1 01010000", v, d);
    else pass_cnt++;
    reg_read(16'h1000, d, v);
    total_cnt++;
    if (v !== 1'b1 || d !== 32'd0) $display("FAIL reset_qcount: v=%b d=%h, required 1 0", v, d);
    else pass_cnt++;
    reg_read(16'h2000, d, v);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL reset_rx_ok: got %h, required 0", d);
    else pass_cnt++;
    @(negedge cmac_clk);
    total_cnt++;
    if (reg_rvalid !== 1'b0) $display("FAIL rvalid_pulse: got %b, required 0", reg_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_registers();
    logic [31:0] d; logic v;
    reg_write(16'h1000, 32'h0000_0200);
    reg_read(16'h1000, d, v);
    total_cnt++;
    if (d !== 32'h200) $display("FAIL qcount_write: got %h, required 200", d);
    else pass_cnt++;
    reg_write(16'h1000, 32'hABCD_FFFF);
    reg_read(16'h1000, d, v);
    total_cnt++;
    if (d !== 32'h200) $display("FAIL qcount_clamp: got %h, required 200", d);
    else pass_cnt++;
    reg_write(16'h0000, 32'h1234_5678);
    reg_read(16'h0000, d, v);
    total_cnt++;
    if (d !== 32'h01010000) $display("FAIL ro_write_ignored: got %h, required 01010000", d);
    else pass_cnt++;
    reg_write(16'h3000, 32'hFFFF_FFFF);
    reg_read(16'h3000, d, v);
    total_cnt++;
    if (v !== 1'b1 || d !== 32'd0) $display("FAIL unmapped_read: v=%b d=%h, required 1 0", v, d);
    else pass_cnt++;
  endtask

  task automatic test_single_beat();
    int n, bad; logic e; logic [15:0] q; logic [31:0] d; logic v;
    send_frame(64, 1'b0, n, e, q, bad);
    total_cnt++;
    if (n !== 1 || e !== 1'b0 || q !== 16'd0 || bad !== 0)
      $display("FAIL single_beat: beats=%0d err=%b qid=%0d bad=%0d, required 1 0 0 0", n, e, q, bad);
    else pass_cnt++;
    reg_read(16'h2000, d, v);
    total_cnt++;
    if (d !== 32'd1) $display("FAIL single_beat_cnt: got %0d, required 1", d);
    else pass_cnt++;
  endtask

  task automatic test_lengths();
    int lens [3] = '{60, 1518, 1519};
    logic exp_err [3] = '{1'b1, 1'b0, 1'b1};
    int exp_beats [3] = '{1, 24, 24};
    int n, bad; logic e; logic [15:0] q; logic [31:0] d; logic v;
    for (int i = 0; i < 3; i++) begin
      send_frame(lens[i], 1'b0, n, e, q, bad);
      total_cnt++;
      if (n !== exp_beats[i] || e !== exp_err[i] || q !== 16'(i + 1) || bad !== 0)
        $display("FAIL length_%0d: beats=%0d err=%b qid=%0d bad=%0d, required %0d %b %0d 0",
                 lens[i], n, e, q, bad, exp_beats[i], exp_err[i], i + 1);
      else pass_cnt++;
    end
    reg_read(16'h2000, d, v);
    total_cnt++;
    if (d !== 32'd2) $display("FAIL length_ok_cnt: got %0d, required 2", d);
    else pass_cnt++;
    reg_read(16'h2004, d, v);
    total_cnt++;
    if (d !== 32'd2) $display("FAIL length_bad_cnt: got %0d, required 2", d);
    else pass_cnt++;
  endtask

  task automatic test_qid_rr();
    int lens [4] = '{64, 128, 100, 1000};
    logic [15:0] exp_q [4] = '{16'd0, 16'd1, 16'd2, 16'd0};
    int n, bad; logic e; logic [15:0] q; logic [31:0] d; logic v;
    reg_write(16'h1000, 32'd3);
    for (int i = 0; i < 4; i++) begin
      send_frame(lens[i], 1'b0, n, e, q, bad);
      total_cnt++;
      if (e !== 1'b0 || q !== exp_q[i] || bad !== 0)
        $display("FAIL qid_rr_%0d: err=%b qid=%0d bad=%0d, required 0 %0d 0", i, e, q, bad, exp_q[i]);
      else pass_cnt++;
    end
    send_frame(64, 1'b1, n, e, q, bad);
    total_cnt++;
    if (e !== 1'b1 || q !== 16'd1 || bad !== 0)
      $display("FAIL err_in_frame: err=%b qid=%0d bad=%0d, required 1 1 0", e, q, bad);
    else pass_cnt++;
    reg_read(16'h2000, d, v);
    total_cnt++;
    if (d !== 32'd6) $display("FAIL rr_ok_cnt: got %0d, required 6", d);
    else pass_cnt++;
    reg_read(16'h2004, d, v);
    total_cnt++;
    if (d !== 32'd3) $display("FAIL rr_bad_cnt: got %0d, required 3", d);
    else pass_cnt++;
  endtask

  task automatic test_rw_collision();
    logic [31:0] d; logic v;
    @(negedge cmac_clk);
    reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 16'h1000; reg_wdata = 32'd5;
    @(negedge cmac_clk);
    reg_wr = 1'b0; reg_rd = 1'b0;
    total_cnt++;
    if (reg_rvalid !== 1'b1 || reg_rdata !== 32'd3)
      $display("FAIL rw_collision: v=%b d=%0d, required 1 3", reg_rvalid, reg_rdata);
    else pass_cnt++;
    reg_read(16'h1000, d, v);
    total_cnt++;
    if (d !== 32'd5) $display("FAIL rw_after: got %0d, required 5", d);
    else pass_cnt++;
  endtask

  task automatic test_tx();
    logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int sent = 0, bad = 0;
    logic [31:0] d; logic v;
    for (int c = 0; c < 20 && sent < 3; c++) begin
      @(negedge cmac_clk);
      tx_out_ready = pat[c % 8];
      tx_in_valid  = 1'b1;
      tx_in_data   = {16{32'hC0DE_0000 | 32'(sent)}};
      tx_in_keep   = (sent == 2) ? 64'h0000_0000_FFFF_FFFF : '1;
      tx_in_last   = (sent == 2);
      #1;
      if (tx_out_valid !== 1'b1 || tx_out_data !== {16{32'hC0DE_0000 | 32'(sent)}} ||
          tx_out_keep !== ((sent == 2) ? 64'h0000_0000_FFFF_FFFF : '1) ||
          tx_out_last !== (sent == 2) || tx_in_ready !== pat[c % 8]) bad++;
      if (pat[c % 8]) sent++;
    end
    @(negedge cmac_clk);
    tx_in_valid = 1'b0; tx_in_last = 1'b0; tx_out_ready = 1'b0;
    total_cnt++;
    if (sent !== 3 || bad !== 0) $display("FAIL tx_passthrough: sent=%0d bad=%0d, required 3 0", sent, bad);
    else pass_cnt++;
    reg_read(16'h2008, d, v);
    total_cnt++;
    if (d !== 32'd1) $display("FAIL tx_cnt: got %0d, required 1", d);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int n, bad; logic e; logic [15:0] q; logic [31:0] d; logic v;
    for (int c = 0; c < 2; c++) begin
      @(negedge cmac_clk);
      rx_in_valid = 1'b1; rx_in_keep = '1; rx_in_last = 1'b0; rx_in_err = 1'b0;
      rx_in_data = '0;
    end
    @(negedge cmac_clk);
    rx_in_valid = 1'b0; cmac_rst = 1'b1;
    @(negedge cmac_clk);
    total_cnt++;
    if (rx_out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b, required 0", rx_out_valid);
    else pass_cnt++;
    cmac_rst = 1'b0;
    send_frame(64, 1'b0, n, e, q, bad);
    total_cnt++;
    if (n !== 1 || e !== 1'b0 || q !== 16'd0 || bad !== 0)
      $display("FAIL after_reset_frame: beats=%0d err=%b qid=%0d bad=%0d, required 1 0 0 0", n, e, q, bad);
    else pass_cnt++;
    reg_read(16'h2000, d, v);
    total_cnt++;
    if (d !== 32'd1) $display("FAIL after_reset_cnt: got %0d, required 1", d);
    else pass_cnt++;
  endtask

  initial begin
    cmac_rst = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    rx_in_valid = 1'b0; rx_in_data = '0; rx_in_keep = '0; rx_in_last = 1'b0; rx_in_err = 1'b0;
    tx_in_valid = 1'b0; tx_in_data = '0; tx_in_keep = '0; tx_in_last = 1'b0; tx_out_ready = 1'b0;
    test_reset();
    test_registers();
    test_single_beat();
    test_lengths();
    test_qid_rr();
    test_rw_collision();
    test_tx();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
